// File: rtl/nios_system_jtag_dbg_pkg.sv
// Shared types, default parameter values and the strobe index helper
// for the sysclk-side JTAG debug command dispatcher.
package nios_system_jtag_dbg_pkg;

    localparam int DEF_CORES   = 4;
    localparam int DEF_IR_W    = 2;
    localparam int DEF_DATA_W  = 38;
    localparam int DEF_SEL_W   = 2;
    localparam int DEF_ACT_BIT = 35;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    // Flat strobe position: each core owns a contiguous block of 2**ir_w codes.
    function automatic int unsigned strobe_idx(input int unsigned core,
                                               input int unsigned ir,
                                               input int unsigned ir_w);
        return core * (32'd1 << ir_w) + ir;
    endfunction

endpackage

// File: rtl/nios_system_jtag_dbg_sync.sv
// Brings a TCK-domain toggle into clk: two metastability flops plus a
// history flop; any change of the synchronised level is a one-cycle event.
module nios_system_jtag_dbg_sync (
    input  logic clk,
    input  logic reset,
    input  logic tgl_i,
    output logic evt_o
);

    logic ff1_q;
    logic ff2_q;
    logic ff3_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
            ff3_q <= 1'b0;
        end else begin
            ff1_q <= tgl_i;
            ff2_q <= ff1_q;
            ff3_q <= ff2_q;
        end
    end

    assign evt_o = ff2_q ^ ff3_q;

endmodule

// File: rtl/nios_system_jtag_debug_dispatch.sv
// Turns each synchronised Update-DR into a one-cycle action / no-action
// strobe for the selected core, then waits for that core's ack or a timeout.
module nios_system_jtag_debug_dispatch
    import nios_system_jtag_dbg_pkg::*;
#(
    parameter int CORES   = DEF_CORES,
    parameter int IR_W    = DEF_IR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SEL_W   = DEF_SEL_W,
    parameter int ACT_BIT = DEF_ACT_BIT,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [IR_W-1:0]             ir_in,
    input  logic [DATA_W-1:0]           sr,
    input  logic                        udr_tgl,
    input  logic                        uir_tgl,
    input  logic [CORES-1:0]            core_ack,
    input  logic                        err_clr,
    output logic [DATA_W-1:0]           jdo,
    output logic [CORES*(2**IR_W)-1:0]  take_action,
    output logic [CORES*(2**IR_W)-1:0]  take_no_action,
    output logic                        uir_pulse,
    output logic                        busy,
    output logic                        timeout_err,
    output logic                        sel_err,
    output logic                        overrun_err
);

    localparam int NSTB  = CORES * (2**IR_W);
    localparam int NSEL  = 2**SEL_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  jdo_q, jdo_d;
    logic [IR_W-1:0]    ir_q, ir_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_err_q, timeout_err_d;
    logic               sel_err_q, sel_err_d;
    logic               overrun_err_q, overrun_err_d;
    logic               uir_pulse_q, uir_pulse_d;

    logic               udr_evt;
    logic               uir_evt;
    logic [SEL_W-1:0]   sr_sel;
    logic               sr_sel_ok;
    logic [NSEL-1:0]    ack_pad;
    logic               ack_sel;
    logic [CNT_W-1:0]   cnt_inc;
    logic [NSTB-1:0]    hit;

    nios_system_jtag_dbg_sync u_udr_sync (
        .clk   (clk),
        .reset (reset),
        .tgl_i (udr_tgl),
        .evt_o (udr_evt)
    );

    nios_system_jtag_dbg_sync u_uir_sync (
        .clk   (clk),
        .reset (reset),
        .tgl_i (uir_tgl),
        .evt_o (uir_evt)
    );

    assign sr_sel    = sr[DATA_W-1 -: SEL_W];
    assign sr_sel_ok = (32'(sr_sel) < CORES);
    assign cnt_inc   = cnt_q + CNT_W'(1);

    // Select field may address more slots than there are cores; unused slots never ack.
    genvar gi;
    for (gi = 0; gi < NSEL; gi++) begin : g_ack
        if (gi < CORES) begin : g_core
            assign ack_pad[gi] = core_ack[gi];
        end else begin : g_none
            assign ack_pad[gi] = 1'b0;
        end
    end
    assign ack_sel = ack_pad[sel_q];

    for (gi = 0; gi < NSTB; gi++) begin : g_hit
        assign hit[gi] = (strobe_idx(32'(sel_q), 32'(ir_q), IR_W) == gi);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            jdo_q         <= '0;
            ir_q          <= '0;
            sel_q         <= '0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
            sel_err_q     <= 1'b0;
            overrun_err_q <= 1'b0;
            uir_pulse_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            jdo_q         <= jdo_d;
            ir_q          <= ir_d;
            sel_q         <= sel_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
            sel_err_q     <= sel_err_d;
            overrun_err_q <= overrun_err_d;
            uir_pulse_q   <= uir_pulse_d;
        end
    end

    always_comb begin
        state_e cur;
        logic   set_sel;
        logic   set_to;
        logic   set_ovr;

        jdo_d   = jdo_q;
        ir_d    = ir_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        set_sel = 1'b0;
        set_to  = 1'b0;
        set_ovr = 1'b0;

        // An Update-IR aborts any outstanding command before a same-cycle Update-DR is looked at.
        cur     = uir_evt ? IDLE : state_q;
        state_d = cur;

        case (cur)
            IDLE: begin
                if (udr_evt) begin
                    jdo_d = sr;
                    ir_d  = ir_in;
                    sel_d = sr_sel;
                    if (sr_sel_ok) begin
                        state_d = ISSUE;
                    end else begin
                        set_sel = 1'b1;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                set_ovr = udr_evt;
                state_d = ack_sel ? IDLE : WAIT;
            end
            WAIT: begin
                cnt_d   = cnt_inc;
                set_ovr = udr_evt;
                if (ack_sel) begin
                    state_d = IDLE;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    set_to  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh error in the same cycle as err_clr keeps its flag set.
        timeout_err_d = (timeout_err_q & ~err_clr) | set_to;
        sel_err_d     = (sel_err_q & ~err_clr) | set_sel;
        overrun_err_d = (overrun_err_q & ~err_clr) | set_ovr;
        uir_pulse_d   = uir_evt;
    end

    always_comb begin
        take_action    = '0;
        take_no_action = '0;
        if (state_q == ISSUE) begin
            if (jdo_q[ACT_BIT]) begin
                take_action = hit;
            end else begin
                take_no_action = hit;
            end
        end
        busy = (state_q != IDLE);
    end

    assign jdo         = jdo_q;
    assign uir_pulse   = uir_pulse_q;
    assign timeout_err = timeout_err_q;
    assign sel_err     = sel_err_q;
    assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_nios_system_jtag_debug_dispatch.sv
// Scoreboarded bench: every accepted command pushes its expected strobe,
// a negedge monitor pops and compares each strobe the dispatcher emits.
module tb_nios_system_jtag_debug_dispatch;

    localparam int CORES   = 4;
    localparam int IR_W    = 2;
    localparam int DATA_W  = 38;
    localparam int SEL_W   = 3;
    localparam int ACT     = 34;
    localparam int TIMEOUT = 10;
    localparam int NSTB    = CORES * (2**IR_W);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [IR_W-1:0]   ir_in = '0;
    logic [DATA_W-1:0] sr = '0;
    logic              udr_tgl = 1'b0;
    logic              uir_tgl = 1'b0;
    logic [CORES-1:0]  core_ack = '0;
    logic              err_clr = 1'b0;
    logic [DATA_W-1:0] jdo;
    logic [NSTB-1:0]   take_action;
    logic [NSTB-1:0]   take_no_action;
    logic              uir_pulse;
    logic              busy;
    logic              timeout_err;
    logic              sel_err;
    logic              overrun_err;

    typedef struct {
        logic [NSTB-1:0]   a;
        logic [NSTB-1:0]   n;
        logic [DATA_W-1:0] jdo;
    } exp_t;

    exp_t              sb_q[$];
    int                n_checks = 0;
    int                n_errors = 0;
    int                n_txn = 0;
    logic [DATA_W-1:0] cur_sr;

    always #5 clk = ~clk;

    nios_system_jtag_debug_dispatch #(
        .CORES(CORES), .IR_W(IR_W), .DATA_W(DATA_W),
        .SEL_W(SEL_W), .ACT_BIT(ACT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr),
        .udr_tgl(udr_tgl), .uir_tgl(uir_tgl), .core_ack(core_ack), .err_clr(err_clr),
        .jdo(jdo), .take_action(take_action), .take_no_action(take_no_action),
        .uir_pulse(uir_pulse), .busy(busy), .timeout_err(timeout_err),
        .sel_err(sel_err), .overrun_err(overrun_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] strobe_vec(input int sel, input int ir, input bit act);
        logic [NSTB-1:0] one;
        one = NSTB'(1) << (sel * (2**IR_W) + ir);
        return act ? 64'({one, NSTB'(0)}) : 64'({NSTB'(0), one});
    endfunction

    // Called 1 time unit after a rising edge; the strobe appears 3 edges later.
    task automatic send_udr(input int sel, input int ir, input bit act, input bit push);
        logic [63:0] r;
        logic [63:0] v;
        exp_t        e;
        r = {$urandom, $urandom};
        cur_sr = r[DATA_W-1:0];
        cur_sr[DATA_W-1 -: SEL_W] = SEL_W'(sel);
        cur_sr[ACT] = act;
        sr = cur_sr;
        ir_in = IR_W'(ir);
        udr_tgl = ~udr_tgl;
        if (push) begin
            v = strobe_vec(sel, ir, act);
            e.a = v[2*NSTB-1:NSTB];
            e.n = v[NSTB-1:0];
            e.jdo = cur_sr;
            sb_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if ((take_action != '0) || (take_no_action != '0)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", 64'({take_action, take_no_action}), 64'(0));
            end else begin
                e = sb_q.pop_front();
                n_txn++;
                check("sb_strobe", 64'({take_action, take_no_action}), 64'({e.a, e.n}));
                check("sb_jdo", 64'(jdo), 64'(e.jdo));
                $display("txn %0d: action=%0h no_action=%0h jdo=%0h", n_txn, take_action, take_no_action, jdo);
            end
        end
    end

    // Full command: ack (plus optional noise on other cores) offered d cycles after the strobe cycle.
    task automatic do_cmd(input int sel, input int ir, input bit act, input int d, input bit noise);
        bit               ok;
        logic [CORES-1:0] own;
        logic [CORES-1:0] mask;
        logic [DATA_W-1:0] sent;
        ok = (sel < CORES);
        own = ok ? CORES'(1) << sel : '0;
        mask = ~own;
        send_udr(sel, ir, act, ok);
        sent = cur_sr;
        repeat (3) step();
        check("strobe_lat", 64'({take_action, take_no_action}), ok ? strobe_vec(sel, ir, act) : 64'(0));
        check("busy_on", 64'(busy), 64'(ok));
        for (int k = 0; k < 15; k++) begin
            core_ack = ((k == d) ? own : '0) | (noise ? (CORES'($urandom) & mask) : '0);
            step();
        end
        core_ack = '0;
        check("busy_off", 64'(busy), 64'(0));
        check("cmd_flags", 64'({timeout_err, sel_err, overrun_err}),
              64'({ok && (d > TIMEOUT - 1 + 1 - 1 + 0) && (d >= TIMEOUT + 1), !ok, 1'b0}));
        check("cmd_jdo", 64'(jdo), 64'(sent));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("flags_clr", 64'({timeout_err, sel_err, overrun_err}), 64'(0));
    endtask

    initial begin
        logic [DATA_W-1:0] saved;

        repeat (3) step();
        check("rst_outs", 64'({take_action, take_no_action, uir_pulse, busy, timeout_err, sel_err, overrun_err}), 64'(0));
        check("rst_jdo", 64'(jdo), 64'(0));
        reset = 1'b0;
        step();

        // Select core 3, action, IR 2; ack 5 cycles after the toggle.
        do_cmd(3, 2, 1'b1, 2, 1'b0);
        // No-action on core 1 IR 0 with acks from other cores as noise.
        do_cmd(1, 0, 1'b0, 3, 1'b1);
        // Out-of-range select.
        do_cmd(5, 1, 1'b1, 0, 1'b0);
        // Ack accepted during the strobe cycle itself.
        do_cmd(2, 3, 1'b1, 0, 1'b0);
        // Ack on the last WAIT cycle wins; one later times out.
        do_cmd(0, 1, 1'b0, TIMEOUT, 1'b0);
        do_cmd(0, 1, 1'b0, TIMEOUT + 1, 1'b0);

        // Exact timeout edge.
        send_udr(2, 1, 1'b1, 1'b1);
        repeat (3) step();
        repeat (TIMEOUT) step();
        check("to_before", 64'({busy, timeout_err}), 64'(2'b10));
        step();
        check("to_fire", 64'({busy, timeout_err}), 64'(2'b01));
        // err_clr on the same edge as a new timeout: flag stays.
        send_udr(1, 2, 1'b0, 1'b1);
        repeat (3) step();
        repeat (TIMEOUT) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_vs_err", 64'({busy, timeout_err}), 64'(2'b01));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("to_clr", 64'(timeout_err), 64'(0));

        // Overrun: second Update-DR while waiting.
        send_udr(2, 1, 1'b1, 1'b1);
        saved = cur_sr;
        repeat (4) step();
        send_udr(3, 0, 1'b0, 1'b0);
        repeat (3) step();
        check("ovr_flag", 64'({busy, overrun_err}), 64'(2'b11));
        check("ovr_jdo", 64'(jdo), 64'(saved));
        core_ack = 4'b0100;
        step();
        core_ack = '0;
        check("ovr_done", 64'(busy), 64'(0));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Update-IR abort during WAIT.
        send_udr(1, 3, 1'b0, 1'b1);
        repeat (4) step();
        uir_tgl = ~uir_tgl;
        repeat (3) step();
        check("abort", 64'({uir_pulse, busy, timeout_err, overrun_err}), 64'(4'b1000));
        step();
        check("uir_one", 64'(uir_pulse), 64'(0));

        // Update-IR and Update-DR together while waiting: abort then accept.
        send_udr(0, 0, 1'b1, 1'b1);
        repeat (4) step();
        send_udr(3, 3, 1'b1, 1'b1);
        saved = cur_sr;
        uir_tgl = ~uir_tgl;
        repeat (3) step();
        check("uir_udr", 64'({uir_pulse, busy, overrun_err}), 64'(3'b110));
        check("uir_udr_jdo", 64'(jdo), 64'(saved));
        core_ack = 4'b1000;
        step();
        core_ack = '0;
        check("uir_udr_done", 64'(busy), 64'(0));

        // Reset during the strobe cycle.
        send_udr(2, 2, 1'b1, 1'b1);
        repeat (3) step();
        reset = 1'b1;
        step();
        check("rst_mid", 64'({take_action, take_no_action, uir_pulse, busy, timeout_err, sel_err, overrun_err}), 64'(0));
        check("rst_mid_jdo", 64'(jdo), 64'(0));
        reset = 1'b0;
        step();
        do_cmd(2, 2, 1'b0, 4, 1'b0);

        // Randomised commands across all cores and IR codes.
        for (int i = 0; i < 40; i++) begin
            do_cmd($urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom),
                   $urandom_range(0, 12), 1'($urandom));
        end

        repeat (3) step();
        check("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
